fp_mul_arbiter: RTL



---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_mul_arbiter_rr.sv | 31 +++
 rtl/fp_mul_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier sharing logic.
// Controller state encoding and datapath width.
package fp_pkg;

   localparam int FP_W     = 32;
   localparam int NREQ_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin picker: first valid request after last_ptr.
// Purely combinational, one-hot grant plus encoded index.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   // scan requesters starting one past the last winner
   always_comb begin
      int idx;
      idx     = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_ptr_i) + k) % NREQ;
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            idx_o        = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one combinational fp_mul32 among NREQ requesters.
// IDLE grants, EXEC lets the multiplier settle, RESP holds result.
module fp_mul_arbiter
   import fp_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   output logic [FP_W-1:0]      resp_result,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [FP_W-1:0]      mul_a,
   output logic [FP_W-1:0]      mul_b,
   input  logic [FP_W-1:0]      mul_result,
   output logic                 busy,
   output logic [CNTW-1:0]      op_count
);

   state_e          state_q;
   logic [IDW-1:0]  owner_q;
   logic [IDW-1:0]  last_q;
   logic [FP_W-1:0] mul_a_q;
   logic [FP_W-1:0] mul_b_q;
   logic [FP_W-1:0] res_q;
   logic [NREQ-1:0] rv_q;
   logic [CNTW-1:0] cnt_q;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  g_idx;
   logic            g_any;
   logic [FP_W-1:0] a_sel_d;
   logic [FP_W-1:0] b_sel_d;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req_i      (req_valid),
      .last_ptr_i (last_q),
      .grant_o    (grant),
      .idx_o      (g_idx),
      .any_o      (g_any)
   );

   // operand mux for the granted port
   always_comb begin
      a_sel_d = '0;
      b_sel_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g_idx == IDW'(i)) begin
            a_sel_d = req_a[i*FP_W +: FP_W];
            b_sel_d = req_b[i*FP_W +: FP_W];
         end
      end
   end

   // controller FSM with registered operands, result and counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         mul_a_q <= '0;
         mul_b_q <= '0;
         res_q   <= '0;
         rv_q    <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (g_any) begin
                  mul_a_q <= a_sel_d;
                  mul_b_q <= b_sel_d;
                  owner_q <= g_idx;
                  last_q  <= g_idx;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= mul_result;
               rv_q    <= NREQ'(1) << owner_q;
               state_q <= RESP;
            end
            RESP: begin
               if (resp_ready[owner_q]) begin
                  rv_q    <= '0;
                  cnt_q   <= cnt_q + CNTW'(1);
                  state_q <= IDLE;
               end
            end
            default: begin
               rv_q    <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE && !reset) ? grant : '0;
   assign resp_valid  = rv_q;
   assign resp_result = res_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign busy        = (state_q != IDLE);
   assign op_count    = cnt_q;

endmodule
